gearbox_tx_hs: RTL

GEARBOX_TX_HS -- requirements
Module: gearbox_tx_hs

---
 rtl/gearbox_tx_hs_if.sv | 37 +++
 rtl/gearbox_tx_hs.sv | 126 ++++++++++++
 2 files changed

// File: rtl/gearbox_tx_hs_if.sv
// ----------------------------------------------------------------------------
// gearbox_tx_hs_if
// Bundle of the gearbox handshake and line signals.
//   sync_i      : synchronous restart request (master -> gearbox)
//   in_valid_i  : input beat valid (master -> gearbox)
//   in_ready_o  : gearbox accepts a beat this cycle (gearbox -> master)
//   head_i      : 2-bit sync header, sampled on the first beat of a block
//   data_i      : payload beat, LSB first on the line
//   out_valid_o : data_o holds a line word
//   data_o      : line word, bit 0 transmitted first
//   seq_o       : current sequence count (0..32)
// The slave modport is the gearbox side; the master modport is the user side.
// ----------------------------------------------------------------------------
interface gearbox_tx_hs_if #(
    parameter int DATA_W = 64,
    parameter int HEAD_W = 2,
    parameter int SEQ_W  = 6
);
    logic              sync_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [HEAD_W-1:0] head_i;
    logic [DATA_W-1:0] data_i;
    logic              out_valid_o;
    logic [DATA_W-1:0] data_o;
    logic [SEQ_W-1:0]  seq_o;

    modport slave (
        input  sync_i, in_valid_i, head_i, data_i,
        output in_ready_o, out_valid_o, data_o, seq_o
    );

    modport master (
        output sync_i, in_valid_i, head_i, data_i,
        input  in_ready_o, out_valid_o, data_o, seq_o
    );
endinterface

// File: rtl/gearbox_tx_hs.sv
// ----------------------------------------------------------------------------
// gearbox_tx_hs
// 64b/66b transmit gearbox with valid/ready input handshake. Each 66-bit block
// (2 header bits then 64 payload bits, LSB first) is packed onto a DATA_W-bit
// line. Every 33 sequence steps the line has consumed exactly 32 input beats
// plus one stall step, during which the accumulated header bits (exactly
// DATA_W of them) are flushed.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : gearbox_tx_hs_if.slave (sync, input handshake, line output, seq)
// ----------------------------------------------------------------------------
module gearbox_tx_hs #(
    parameter int DATA_W  = 64,
    parameter int BLOCK_W = 64,
    parameter int HEAD_W  = 2,
    parameter int SEQ_W   = 6
) (
    input  logic            clk,
    input  logic            reset,
    gearbox_tx_hs_if.slave  bus
);
    // Elaboration-time legality checks
    if (!(DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $error("gearbox_tx_hs: DATA_W must be 16, 32 or 64");
    end
    if (BLOCK_W != 64) begin : g_bad_block_w
        $error("gearbox_tx_hs: BLOCK_W must be 64");
    end
    if (HEAD_W != 2) begin : g_bad_head_w
        $error("gearbox_tx_hs: HEAD_W must be 2");
    end
    if (SEQ_W < 6) begin : g_bad_seq_w
        $error("gearbox_tx_hs: SEQ_W must cover 0..32");
    end

    localparam int BPB    = BLOCK_W / DATA_W;       // beats per block
    localparam int BEAT_W = 2;                      // holds up to 4 beats
    localparam int OCC_W  = $clog2(DATA_W + 1);     // residual bit count
    localparam logic [SEQ_W-1:0]  SEQ_STALL = SEQ_W'(32);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BPB - 1);

    logic [SEQ_W-1:0]    seq_q,   seq_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [OCC_W-1:0]    occ_q,   occ_d;
    logic [DATA_W-1:0]   resid_q, resid_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic                vld_q,   vld_d;

    logic                stall;
    logic                ready;
    logic                accept;
    logic [2*DATA_W-1:0] new_bits;
    logic [2*DATA_W-1:0] merged;

    assign stall  = (seq_q == SEQ_STALL);
    // Ready is forced low combinationally while reset is asserted.
    assign ready  = ~reset & ~stall;
    assign accept = bus.in_valid_i & ready;

    always_comb begin
        seq_d   = seq_q;
        beat_d  = beat_q;
        occ_d   = occ_q;
        resid_d = resid_q;
        data_d  = data_q;
        vld_d   = 1'b0;

        // Header bits go ahead of the payload only on beat 0 of a block.
        if (beat_q == '0) begin
            new_bits = {{(DATA_W - HEAD_W){1'b0}}, bus.data_i, bus.head_i};
        end else begin
            new_bits = {{DATA_W{1'b0}}, bus.data_i};
        end
        // Residual bits leave first, so new bits sit just above them.
        // Bits of resid_q above occ_q are always zero.
        merged = (new_bits << occ_q) | {{DATA_W{1'b0}}, resid_q};

        if (bus.sync_i) begin
            seq_d   = '0;
            beat_d  = '0;
            occ_d   = '0;
            resid_d = '0;
        end else if (stall) begin
            // Residual is exactly DATA_W bits here: flush it whole.
            data_d  = resid_q;
            resid_d = '0;
            occ_d   = '0;
            beat_d  = '0;
            seq_d   = '0;
            vld_d   = 1'b1;
        end else if (accept) begin
            data_d  = merged[DATA_W-1:0];
            resid_d = merged[2*DATA_W-1:DATA_W];
            if (beat_q == '0) begin
                occ_d = occ_q + OCC_W'(HEAD_W);
            end
            beat_d  = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
            seq_d   = seq_q + SEQ_W'(1);
            vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q   <= '0;
            beat_q  <= '0;
            occ_q   <= '0;
            resid_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            beat_q  <= beat_d;
            occ_q   <= occ_d;
            resid_q <= resid_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.in_ready_o  = ready;
    assign bus.out_valid_o = vld_q;
    assign bus.data_o      = data_q;
    assign bus.seq_o       = seq_q;
endmodule
